vec_alu_sequencer: RTL and testbench
====================================

// Module: vec_alu_sequencer
// PURPOSE
// Initiator side of the lane ALU interface. Accepts one vector instruction (opcode + VL) and streams VL
// element operand beats into the ALU, one per cycle. Tracks multiplier pipeline latency and emits
// element-indexed writebacks to the lane register file. Sits between lane operand fetch and the ALU/VRF write port.
// PARAMETERS
// DATA_WIDTH  32  element width; must match the ALU.
// PIPE_ST     5   ALU multiplier stages; MUL-class latency is L=PIPE_ST-1 cycles. Must be >=2.
// MAX_VL      32  maximum elements per instruction; IDX_W=$clog2(MAX_VL).
// PORTS
// clk_i          in   1            clock
// resetn_i       in   1            reset, synchronous, active-low
// instr_valid_i  in   1            instruction offered
// instr_ready_o  out  1            high only in IDLE
// instr_op_i     in   7            {funct, category} opcode, vect_pkg encoding
// instr_vl_i     in   IDX_W+1      element count, 0..MAX_VL
// op_valid_i     in   1            operand beat offered
// op_ready_o     out  1            high only in ISSUE
// op_a_i/op_b_i/op_c_i in DATA_WIDTH  vs1, vs2, vd(accumulator) element operands
// op_mask_i      in   1            element mask bit (1=active)
// alu_valid_o    out  1            ALU valid_i
// alu_mask_en_o  out  1            ALU mask_en_i
// alu_a_o/alu_b_o/alu_c_o out DATA_WIDTH  ALU operands
// alu_op_o       out  7            ALU opcode_i
// alu_q_i        in   DATA_WIDTH   ALU result
// wb_valid_o     out  1            writeback strobe, registered
// wb_we_o        out  1            element active; VRF writes only if wb_valid_o&wb_we_o
// wb_idx_o       out  IDX_W        element index
// wb_data_o      out  DATA_WIDTH   result
// done_o         out  1            1-cycle pulse, instruction retired
// err_o          out  1            1-cycle pulse with done_o, opcode rejected
// BEHAVIOUR
// - Reset (resetn_i low at posedge): state=IDLE; every output 0 except instr_ready_o=1.
//   Tag pipe, counters, latched opcode cleared. Reset mid-instruction abandons it; no done_o is issued.
// - Class, decoded at accept: MUL = VMUL/VMULH/VMULHU/VMULHSU/VMACC/VMADD/VNMSAC/VNMSUB with MULT category.
//   DIV = VDIV/VDIVU/VREM/VREMU with MULT category. All others are ALU class.
// - FSM IDLE->ISSUE on instr_valid_i: latch op, vl; elem counter=0.
//   - vl==0 goes straight to DONE; DIV class goes to DONE with err_o; neither issues any beat.
// - ISSUE: op_ready_o=1; beat accepted when op_valid_i. Last accept: ALU class ->DONE; MUL class ->DRAIN.
// - DRAIN: exactly L cycles, then DONE. DONE: done_o=1 (err_o if flagged) for one cycle, then IDLE.
// - alu_op_o = latched op in ISSUE/DRAIN, 0 otherwise; held constant for the whole instruction.
//   This is required because the ALU decodes MUL results with the current opcode.
// - ALU class: alu_valid_o = accept; alu_mask_en_o = accept & op_mask_i; operands pass through
//   combinationally on accept, else 0. alu_q_i is sampled the same cycle. wb registered next cycle:
//   wb_valid_o=1, wb_we_o=mask, wb_idx_o=elem index.
// - MUL class: alu_valid_o=alu_mask_en_o=1 for every ISSUE/DRAIN cycle, including bubbles and masked elements.
//   This keeps the multiplier enable high so its pipe advances one stage per cycle. Operands are 0 on bubbles.
// - MUL tag pipe: L-deep shift of {valid,mask,idx}, shifted every ISSUE/DRAIN cycle. Entry valid = accept.
//   When the tag exits valid, alu_q_i is sampled and wb is registered next cycle. Masking is applied via wb_we_o only.
// - Timing: last beat accepted at T gives the final wb and done_o in the same cycle.
//   That cycle is T+1 (ALU class) or T+PIPE_ST (MUL class).
// - Elem counter width IDX_W+1; wb_idx_o never wraps (vl<=MAX_VL). instr_vl_i>MAX_VL is clamped to MAX_VL.
// - Simultaneous instr_valid_i in DONE: not accepted; accepted next cycle in IDLE.
// TESTING
// - VADD vl=4, back-to-back beats a=1..4, b=10 -> wb_data 11,12,13,14, idx 0..3, T+1 each; done_o with idx3.
// - VMUL PIPE_ST=5 vl=3, a=3, b=5,6,7, bubble between beat 1 and 2 -> wb 15,18,21 at accept+5; DRAIN 4 cycles.
// - VMACC vl=2 masks {1,0}, a=2, b=4, c=100 -> idx0 wb_we=1 data 108; idx1 wb_valid=1 wb_we=0; no pipe stall.
// - vl=0 VADD -> done_o 2 cycles after accept, no op_ready_o, no wb_valid_o; VDIV vl=4 -> done_o&err_o, no beats.
// - Reset asserted in DRAIN with 2 tags in flight -> next cycle IDLE, all outputs 0, no wb/done; new VADD is then correct.

Source files
------------

// File: rtl/vec_alu_sequencer_if.sv
// rtl/vec_alu_sequencer_if.sv - instruction, operand, ALU and writeback signals of the lane ALU sequencer
// master is the sequencer side; slave is operand fetch / ALU / VRF side.
interface vec_alu_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_VL     = 32
);
  localparam int IDX_W = $clog2(MAX_VL);

  logic                  instr_valid_i;
  logic                  instr_ready_o;
  logic [6:0]            instr_op_i;
  logic [IDX_W:0]        instr_vl_i;

  logic                  op_valid_i;
  logic                  op_ready_o;
  logic [DATA_WIDTH-1:0] op_a_i;
  logic [DATA_WIDTH-1:0] op_b_i;
  logic [DATA_WIDTH-1:0] op_c_i;
  logic                  op_mask_i;

  logic                  alu_valid_o;
  logic                  alu_mask_en_o;
  logic [DATA_WIDTH-1:0] alu_a_o;
  logic [DATA_WIDTH-1:0] alu_b_o;
  logic [DATA_WIDTH-1:0] alu_c_o;
  logic [6:0]            alu_op_o;
  logic [DATA_WIDTH-1:0] alu_q_i;

  logic                  wb_valid_o;
  logic                  wb_we_o;
  logic [IDX_W-1:0]      wb_idx_o;
  logic [DATA_WIDTH-1:0] wb_data_o;

  logic                  done_o;
  logic                  err_o;

  modport master (
    input  instr_valid_i, instr_op_i, instr_vl_i,
    input  op_valid_i, op_a_i, op_b_i, op_c_i, op_mask_i,
    input  alu_q_i,
    output instr_ready_o, op_ready_o,
    output alu_valid_o, alu_mask_en_o, alu_a_o, alu_b_o, alu_c_o, alu_op_o,
    output wb_valid_o, wb_we_o, wb_idx_o, wb_data_o,
    output done_o, err_o
  );

  modport slave (
    output instr_valid_i, instr_op_i, instr_vl_i,
    output op_valid_i, op_a_i, op_b_i, op_c_i, op_mask_i,
    output alu_q_i,
    input  instr_ready_o, op_ready_o,
    input  alu_valid_o, alu_mask_en_o, alu_a_o, alu_b_o, alu_c_o, alu_op_o,
    input  wb_valid_o, wb_we_o, wb_idx_o, wb_data_o,
    input  done_o, err_o
  );
endinterface

// File: rtl/vec_alu_sequencer.sv
// rtl/vec_alu_sequencer.sv - vector instruction sequencer driving the lane ALU and VRF writeback
// Issues one operand beat per cycle, tracks multiplier latency with a tag pipe, retires with done_o.
module vec_alu_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int PIPE_ST    = 5,
  parameter int MAX_VL     = 32
) (
  input logic                 clk_i,
  input logic                 resetn_i,
  vec_alu_sequencer_if.master bus
);
  localparam int IDX_W = $clog2(MAX_VL);
  localparam int L     = PIPE_ST - 1;
  localparam int DC_W  = (L > 1) ? $clog2(L) : 1;

  localparam logic [DC_W-1:0]  DRAIN_LAST = DC_W'(L - 1);
  localparam logic [IDX_W:0]   VL_MAX     = (IDX_W + 1)'(MAX_VL);
  localparam logic [IDX_W:0]   ONE        = (IDX_W + 1)'(1);
  localparam logic [2:0]       CAT_MULT   = 3'd2;
  localparam logic [3:0]       F_MUL_LAST = 4'd7;
  localparam logic [3:0]       F_DIV_FIRST = 4'd8;
  localparam logic [3:0]       F_DIV_LAST = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t              state;
  logic [IDX_W:0]      vl_q;
  logic [IDX_W:0]      elem_q;
  logic                mul_q;
  logic                div_q;
  logic [DC_W-1:0]     drain_cnt;
  logic [6:0]          alu_op_q;
  logic                instr_ready_q;
  logic                op_ready_q;
  logic                done_q;
  logic                err_q;
  logic                wb_valid_q;
  logic                wb_we_q;
  logic [IDX_W-1:0]    wb_idx_q;
  logic [DATA_WIDTH-1:0] wb_data_q;

  logic [L-1:0]        tag_v;
  logic [L-1:0]        tag_m;
  logic [IDX_W-1:0]    tag_idx [L];

  logic                dec_mul;
  logic                dec_div;
  logic [IDX_W:0]      vl_clamped;
  logic                accept;
  logic                last_beat;
  logic                mul_active;

  always_comb begin
    dec_mul    = 1'b0;
    dec_div    = 1'b0;
    if (bus.instr_op_i[2:0] == CAT_MULT) begin
      dec_mul = bus.instr_op_i[6:3] <= F_MUL_LAST;
      dec_div = (bus.instr_op_i[6:3] >= F_DIV_FIRST) && (bus.instr_op_i[6:3] <= F_DIV_LAST);
    end
    vl_clamped = (bus.instr_vl_i > VL_MAX) ? VL_MAX : bus.instr_vl_i;
  end

  assign accept     = op_ready_q & bus.op_valid_i;
  assign last_beat  = accept && ((elem_q + ONE) == vl_q);
  // MUL class keeps the multiplier enabled through bubbles and drain so its pipe never stalls
  assign mul_active = mul_q && (op_ready_q || (state == S_DRAIN));

  assign bus.alu_valid_o   = mul_active | (~mul_q & accept);
  assign bus.alu_mask_en_o = mul_active | (~mul_q & accept & bus.op_mask_i);
  assign bus.alu_a_o       = accept ? bus.op_a_i : '0;
  assign bus.alu_b_o       = accept ? bus.op_b_i : '0;
  assign bus.alu_c_o       = accept ? bus.op_c_i : '0;
  assign bus.alu_op_o      = alu_op_q;

  assign bus.instr_ready_o = instr_ready_q;
  assign bus.op_ready_o    = op_ready_q;
  assign bus.wb_valid_o    = wb_valid_q;
  assign bus.wb_we_o       = wb_we_q;
  assign bus.wb_idx_o      = wb_idx_q;
  assign bus.wb_data_o     = wb_data_q;
  assign bus.done_o        = done_q;
  assign bus.err_o         = err_q;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state         <= S_IDLE;
      vl_q          <= '0;
      elem_q        <= '0;
      mul_q         <= 1'b0;
      div_q         <= 1'b0;
      drain_cnt     <= '0;
      alu_op_q      <= '0;
      instr_ready_q <= 1'b1;
      op_ready_q    <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_we_q       <= 1'b0;
      wb_idx_q      <= '0;
      wb_data_q     <= '0;
      tag_v         <= '0;
      tag_m         <= '0;
      for (int i = 0; i < L; i++) tag_idx[i] <= '0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_idx_q   <= '0;
      wb_data_q  <= '0;

      // Writeback: ALU class on the accept cycle, MUL class when a tag leaves the pipe
      if (!mul_q && accept) begin
        wb_valid_q <= 1'b1;
        wb_we_q    <= bus.op_mask_i;
        wb_idx_q   <= elem_q[IDX_W-1:0];
        wb_data_q  <= bus.alu_q_i;
      end else if (mul_q && tag_v[L-1]) begin
        wb_valid_q <= 1'b1;
        wb_we_q    <= tag_m[L-1];
        wb_idx_q   <= tag_idx[L-1];
        wb_data_q  <= bus.alu_q_i;
      end

      if (mul_active) begin
        for (int i = L - 1; i > 0; i--) begin
          tag_v[i]   <= tag_v[i-1];
          tag_m[i]   <= tag_m[i-1];
          tag_idx[i] <= tag_idx[i-1];
        end
        tag_v[0]   <= accept;
        tag_m[0]   <= bus.op_mask_i;
        tag_idx[0] <= elem_q[IDX_W-1:0];
      end

      if (accept) elem_q <= elem_q + ONE;

      case (state)
        S_IDLE: begin
          if (bus.instr_valid_i) begin
            state         <= S_ISSUE;
            instr_ready_q <= 1'b0;
            alu_op_q      <= bus.instr_op_i;
            vl_q          <= vl_clamped;
            elem_q        <= '0;
            mul_q         <= dec_mul;
            div_q         <= dec_div;
            op_ready_q    <= (vl_clamped != '0) && !dec_div;
          end
        end
        S_ISSUE: begin
          // Empty or rejected instructions spend one ISSUE cycle without offering op_ready
          if ((vl_q == '0) || div_q) begin
            state    <= S_DONE;
            done_q   <= 1'b1;
            err_q    <= div_q;
            alu_op_q <= '0;
          end else if (last_beat) begin
            op_ready_q <= 1'b0;
            if (mul_q) begin
              state     <= S_DRAIN;
              drain_cnt <= '0;
            end else begin
              state    <= S_DONE;
              done_q   <= 1'b1;
              alu_op_q <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state    <= S_DONE;
            done_q   <= 1'b1;
            alu_op_q <= '0;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state         <= S_IDLE;
          instr_ready_q <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vec_alu_sequencer.sv
// tb/tb_vec_alu_sequencer.sv - scoreboard bench for vec_alu_sequencer with a pipelined ALU model
// Driver pushes expected writebacks/retires; a negedge monitor pops and compares.
module tb_vec_alu_sequencer;
  localparam int DW      = 32;
  localparam int PIPE_ST = 5;
  localparam int MAX_VL  = 32;
  localparam int L       = PIPE_ST - 1;
  localparam int IDX_W   = $clog2(MAX_VL);

  localparam logic [2:0] CAT_ALU  = 3'd0;
  localparam logic [2:0] CAT_MULT = 3'd2;
  localparam logic [6:0] VADD   = {4'd0, CAT_ALU};
  localparam logic [6:0] VSUB   = {4'd1, CAT_ALU};
  localparam logic [6:0] VAND   = {4'd2, CAT_ALU};
  localparam logic [6:0] VXOR   = {4'd3, CAT_ALU};
  localparam logic [6:0] VMUL   = {4'd0, CAT_MULT};
  localparam logic [6:0] VMULH  = {4'd1, CAT_MULT};
  localparam logic [6:0] VMACC  = {4'd4, CAT_MULT};
  localparam logic [6:0] VMADD  = {4'd5, CAT_MULT};
  localparam logic [6:0] VNMSAC = {4'd6, CAT_MULT};
  localparam logic [6:0] VNMSUB = {4'd7, CAT_MULT};
  localparam logic [6:0] VDIV   = {4'd8, CAT_MULT};
  localparam logic [6:0] VREMU  = {4'd11, CAT_MULT};

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  vec_alu_sequencer_if #(.DATA_WIDTH(DW), .MAX_VL(MAX_VL)) bus ();

  vec_alu_sequencer #(.DATA_WIDTH(DW), .PIPE_ST(PIPE_ST), .MAX_VL(MAX_VL)) dut (
    .clk_i    (clk),
    .resetn_i (resetn),
    .bus      (bus.master)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit is_mul_op(input logic [6:0] op);
    return (op[2:0] == CAT_MULT) && (op[6:3] <= 4'd7);
  endfunction

  function automatic bit is_div_op(input logic [6:0] op);
    return (op[2:0] == CAT_MULT) && (op[6:3] >= 4'd8) && (op[6:3] <= 4'd11);
  endfunction

  // Element semantics: a=vs1, b=vs2, c=vd
  function automatic logic [31:0] alu_fn(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
    longint sa, sb, sp;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sp = sa * sb;
    case (op)
      VADD:    return a + b;
      VSUB:    return b - a;
      VAND:    return a & b;
      VXOR:    return a ^ b;
      VMUL:    return a * b;
      VMULH:   return sp[63:32];
      VMACC:   return a * b + c;
      VMADD:   return c * a + b;
      VNMSAC:  return c - a * b;
      VNMSUB:  return b - c * a;
      default: return 32'd0;
    endcase
  endfunction

  // ALU model: combinational for ALU class, L-stage pipe advancing on valid&mask_en for MUL class
  logic [31:0] mpipe [L];
  initial for (int i = 0; i < L; i++) mpipe[i] = '0;
  always @(posedge clk) begin
    if (bus.alu_valid_o && bus.alu_mask_en_o && is_mul_op(bus.alu_op_o)) begin
      mpipe[0] <= alu_fn(bus.alu_op_o, bus.alu_a_o, bus.alu_b_o, bus.alu_c_o);
      for (int i = L - 1; i > 0; i--) mpipe[i] <= mpipe[i-1];
    end
  end
  assign bus.alu_q_i = is_mul_op(bus.alu_op_o) ? mpipe[L-1]
                                               : alu_fn(bus.alu_op_o, bus.alu_a_o, bus.alu_b_o, bus.alu_c_o);

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [IDX_W-1:0] idx; logic we; logic [31:0] data; } wb_exp_t;
  typedef struct { int due; logic err; } done_exp_t;
  wb_exp_t   wb_q[$];
  done_exp_t done_q[$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.wb_valid_o) begin
        check("wb_expected", wb_q.size() != 0, bus.wb_idx_o, -1);
        if (wb_q.size() != 0) begin
          wb_exp_t e;
          e = wb_q.pop_front();
          check("wb_cycle", cyc == e.due, cyc, e.due);
          check("wb_idx", bus.wb_idx_o == e.idx, bus.wb_idx_o, e.idx);
          check("wb_we", bus.wb_we_o == e.we, bus.wb_we_o, e.we);
          if (e.we) check("wb_data", bus.wb_data_o == e.data, bus.wb_data_o, e.data);
        end
      end
      if (bus.done_o || bus.err_o) begin
        check("done_expected", bus.done_o && done_q.size() != 0, bus.done_o, 1);
        if (done_q.size() != 0) begin
          done_exp_t d;
          d = done_q.pop_front();
          check("done_cycle", cyc == d.due, cyc, d.due);
          check("done_err", bus.err_o == d.err, bus.err_o, d.err);
        end
      end
    end
  end

  logic [31:0] a_arr [MAX_VL];
  logic [31:0] b_arr [MAX_VL];
  logic [31:0] c_arr [MAX_VL];
  logic        m_arr [MAX_VL];
  int          bub_arr [MAX_VL];

  task automatic clear_beat();
    bus.op_valid_i = 1'b0;
    bus.op_a_i     = '0;
    bus.op_b_i     = '0;
    bus.op_c_i     = '0;
    bus.op_mask_i  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!bus.instr_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, n < 100, n, 0);
  endtask

  // Called at a negedge; returns at a negedge with the sequencer idle again
  task automatic run_instr(input logic [6:0] op, input int vl);
    int vlc, ta, tacc, due;
    bit mul, div;
    vlc = (vl > MAX_VL) ? MAX_VL : vl;
    mul = is_mul_op(op);
    div = is_div_op(op);
    bus.instr_valid_i = 1'b1;
    bus.instr_op_i    = op;
    bus.instr_vl_i    = (IDX_W + 1)'(vl);
    wait_idle("instr_accept_wait");
    ta = cyc;
    @(negedge clk);
    bus.instr_valid_i = 1'b0;
    if (vlc == 0 || div) begin
      #1;
      check("no_op_ready", bus.op_ready_o == 1'b0, bus.op_ready_o, 0);
      done_q.push_back('{due: ta + 2, err: div});
    end else begin
      for (int e = 0; e < vlc; e++) begin
        for (int k = 0; k < bub_arr[e]; k++) begin
          clear_beat();
          #1;
          if (mul) check("mul_bubble_en", bus.alu_valid_o && bus.alu_mask_en_o, bus.alu_valid_o, 1);
          else check("alu_bubble_idle", !bus.alu_valid_o, bus.alu_valid_o, 0);
          @(negedge clk);
        end
        bus.op_valid_i = 1'b1;
        bus.op_a_i     = a_arr[e];
        bus.op_b_i     = b_arr[e];
        bus.op_c_i     = c_arr[e];
        bus.op_mask_i  = m_arr[e];
        #1;
        check("op_ready", bus.op_ready_o == 1'b1, bus.op_ready_o, 1);
        check("alu_op_hold", bus.alu_op_o == op, bus.alu_op_o, op);
        if (mul) check("mul_en_high", bus.alu_valid_o && bus.alu_mask_en_o, bus.alu_mask_en_o, 1);
        else check("alu_mask_en", bus.alu_valid_o && (bus.alu_mask_en_o == m_arr[e]),
                   bus.alu_mask_en_o, m_arr[e]);
        tacc = cyc;
        due  = tacc + (mul ? PIPE_ST : 1);
        wb_q.push_back('{due: due, idx: IDX_W'(e), we: m_arr[e], data: alu_fn(op, a_arr[e], b_arr[e], c_arr[e])});
        if (e == vlc - 1) done_q.push_back('{due: due, err: 1'b0});
        @(negedge clk);
      end
      clear_beat();
    end
    wait_idle("retire_wait");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr_ready"}, bus.instr_ready_o == 1'b1, bus.instr_ready_o, 1);
    check({tag, "_op_ready"}, bus.op_ready_o == 1'b0, bus.op_ready_o, 0);
    check({tag, "_alu_valid"}, (bus.alu_valid_o | bus.alu_mask_en_o) == 1'b0, bus.alu_valid_o, 0);
    check({tag, "_alu_op"}, bus.alu_op_o == 7'd0, bus.alu_op_o, 0);
    check({tag, "_wb_valid"}, bus.wb_valid_o == 1'b0, bus.wb_valid_o, 0);
    check({tag, "_done_err"}, (bus.done_o | bus.err_o) == 1'b0, bus.done_o, 0);
  endtask

  logic [6:0] rand_ops [12] = '{VADD, VSUB, VAND, VXOR, VMUL, VMULH, VMACC, VMADD, VNMSAC, VNMSUB, VDIV, VREMU};

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_valid_i = 1'b0;
    bus.instr_op_i    = '0;
    bus.instr_vl_i    = '0;
    clear_beat();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    for (int e = 0; e < 4; e++) begin
      a_arr[e] = 32'(e + 1); b_arr[e] = 32'd10; c_arr[e] = '0; m_arr[e] = 1'b1; bub_arr[e] = 0;
    end
    run_instr(VADD, 4);

    for (int e = 0; e < 3; e++) begin
      a_arr[e] = 32'd3; b_arr[e] = 32'(5 + e); c_arr[e] = '0; m_arr[e] = 1'b1; bub_arr[e] = (e == 1) ? 1 : 0;
    end
    run_instr(VMUL, 3);

    for (int e = 0; e < 2; e++) begin
      a_arr[e] = 32'd2; b_arr[e] = 32'd4; c_arr[e] = 32'd100; m_arr[e] = (e == 0); bub_arr[e] = 0;
    end
    run_instr(VMACC, 2);

    run_instr(VADD, 0);
    run_instr(VDIV, 4);

    for (int e = 0; e < MAX_VL; e++) begin
      a_arr[e] = $urandom; b_arr[e] = $urandom; c_arr[e] = '0; m_arr[e] = 1'b1; bub_arr[e] = 0;
    end
    run_instr(VADD, MAX_VL + 5);

    // Reset during DRAIN with two multiplier tags outstanding
    bus.instr_valid_i = 1'b1;
    bus.instr_op_i    = VMUL;
    bus.instr_vl_i    = (IDX_W + 1)'(2);
    wait_idle("rst_accept_wait");
    @(negedge clk);
    bus.instr_valid_i = 1'b0;
    for (int e = 0; e < 2; e++) begin
      bus.op_valid_i = 1'b1; bus.op_a_i = 32'd7; bus.op_b_i = 32'(e + 9); bus.op_mask_i = 1'b1;
      @(negedge clk);
    end
    clear_beat();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check_reset_outputs("rst_drain");
    repeat (PIPE_ST + 2) @(negedge clk);

    for (int e = 0; e < 3; e++) begin
      a_arr[e] = 32'(20 * e); b_arr[e] = 32'd5; c_arr[e] = '0; m_arr[e] = 1'b1; bub_arr[e] = 0;
    end
    run_instr(VADD, 3);

    for (int t = 0; t < 30; t++) begin
      logic [6:0] op;
      int vl;
      op = rand_ops[$urandom_range(0, 11)];
      vl = $urandom_range(0, 9);
      for (int e = 0; e < MAX_VL; e++) begin
        a_arr[e]   = $urandom;
        b_arr[e]   = $urandom;
        c_arr[e]   = $urandom;
        m_arr[e]   = ($urandom_range(0, 3) != 0);
        bub_arr[e] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      end
      run_instr(op, vl);
    end

    repeat (PIPE_ST + 3) @(negedge clk);
    check("wb_queue_drained", wb_q.size() == 0, wb_q.size(), 0);
    check("done_queue_drained", done_q.size() == 0, done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
